// File: rtl/case_stream_converter.sv
// Letter-case converter for a byte-lane stream: per-lane case conversion feeding a 2-entry
// output FIFO, plus a saturating count of the bytes actually modified.
module case_stream_converter #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [LANES-1:0]   in_keep,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    output logic               out_last,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   conv_count
);

    localparam int unsigned DataW = 8 * LANES;
    localparam int unsigned NumW  = $clog2(LANES + 1);
    localparam int unsigned SumW  = CNT_W + 5;

    // Bit 5 of a letter changes only when the mode moves it to the other case.
    function automatic logic lane_flips(input logic [1:0] m, input logic [7:0] b);
        logic is_up;
        logic is_lo;
        is_up = (b >= 8'h41) && (b <= 8'h5A);
        is_lo = (b >= 8'h61) && (b <= 8'h7A);
        case (m)
            2'b01:   lane_flips = is_lo;
            2'b10:   lane_flips = is_up;
            2'b11:   lane_flips = is_up | is_lo;
            default: lane_flips = 1'b0;
        endcase
    endfunction

    logic [DataW-1:0] conv_data;
    logic [NumW-1:0]  n_mod;

    always_comb begin
        conv_data = in_data;
        n_mod     = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (in_keep[i] && lane_flips(mode, in_data[8*i +: 8])) begin
                conv_data[8*i+5] = ~in_data[8*i+5];
                n_mod            = n_mod + NumW'(1);
            end
        end
    end

    logic [DataW-1:0] data_q [2];
    logic [LANES-1:0] keep_q [2];
    logic             last_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SumW-1:0]  sum;
    logic             accept, pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_comb begin
        occ_d      = occ_q + 2'(accept) - 2'(pop);
        in_ready_d = (occ_d < 2'd2);
    end

    assign sum = SumW'(cnt_q) + SumW'(n_mod);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                data_q[wr_ptr_q] <= conv_data;
                keep_q[wr_ptr_q] <= in_keep;
                last_q[wr_ptr_q] <= in_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = data_q[rd_ptr_q];
    assign out_keep   = keep_q[rd_ptr_q];
    assign out_last   = last_q[rd_ptr_q];
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_case_stream_converter.sv
// Randomized scoreboard bench for case_stream_converter with directed corner scenarios.
module tb_case_stream_converter;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic [3:0]       in_keep = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [3:0]       out_keep;
    logic             out_last;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] conv_count;

    case_stream_converter #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .cnt_clr(cnt_clr), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    n_acc = 0;
    int    n_pop = 0;
    int    exp_cnt = 0;
    bit    chk_en = 1'b0;
    bit    rdy_rand = 1'b0;
    bit    rdy_force = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: case handled as ASCII arithmetic on letter ranges.
    function automatic logic [7:0] ref_byte(input logic [1:0] m, input logic [7:0] b);
        int  v;
        bit  up, lo;
        v  = int'(b);
        up = (v >= 65) && (v <= 90);
        lo = (v >= 97) && (v <= 122);
        case (m)
            2'd1: if (lo) v = v - 32;
            2'd2: if (up) v = v + 32;
            2'd3: if (up) v = v + 32; else if (lo) v = v - 32;
            default: ;
        endcase
        return 8'(v);
    endfunction

    task automatic ref_beat(input logic [1:0] m, input logic [31:0] d, input logic [3:0] k,
                            output logic [31:0] o, output int nmod);
        logic [7:0] a, r;
        o    = d;
        nmod = 0;
        for (int i = 0; i < 4; i++) begin
            a = d[8*i +: 8];
            r = ref_byte(m, a);
            if (k[i] && (r != a)) begin
                o[8*i +: 8] = r;
                nmod++;
            end
        end
    endtask

    // One cycle of stimulus; expected results are queued when the handshake is seen.
    task automatic drive(input logic [1:0] m, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic clr, output bit acc);
        logic [31:0] o;
        int          nm;
        beat_t       e;
        @(posedge clk);
        #1;
        mode = m; in_data = d; in_keep = k; in_last = l; cnt_clr = clr; in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        nm  = 0;
        if (acc) begin
            ref_beat(m, d, k, o, nm);
            e.d = o; e.k = k; e.l = l;
            sb.push_back(e);
            n_acc++;
        end
        if (clr) exp_cnt = 0;
        else if (acc) exp_cnt = (exp_cnt + nm > int'(CMAX)) ? int'(CMAX) : exp_cnt + nm;
    endtask

    task automatic offer(input logic [1:0] m, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic clr);
        bit acc;
        int tries;
        tries = 0;
        do begin
            drive(m, d, k, l, clr, acc);
            tries++;
        end while (!acc && tries < 100);
        if (!acc) check("offer_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle_begin();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic drain();
        int t;
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            idle_begin();
            t++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] edges [8];
        edges = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h41, 8'h5A, 8'h61, 8'h7A};
        case ($urandom_range(0, 3))
            0: return 8'(8'h41 + $urandom_range(0, 25));
            1: return 8'(8'h61 + $urandom_range(0, 25));
            2: return edges[$urandom_range(0, 7)];
            default: return 8'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Pop monitor: compare the FIFO head against the scoreboard whenever a beat leaves.
    always @(negedge clk) begin
        if (chk_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.d);
                check("out_keep", 32'(out_keep), 32'(e.k));
                check("out_last", 32'(out_last), 32'(e.l));
            end
            n_pop++;
        end
    end

    // Flow-control and counter monitor, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'((n_acc - n_pop) < 2));
            check("out_valid", 32'(out_valid), 32'((n_acc - n_pop) > 0));
            check("conv_count", 32'(conv_count), 32'(exp_cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [31:0] d;

        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_count", 32'(conv_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        chk_en    = 1'b1;
        rdy_force = 1'b1;

        offer(2'b01, 32'h7A41_6131, 4'hF, 1'b0, 1'b0);
        idle_begin();
        check("s1_latency", 32'(out_valid), 32'd1);
        check("s1_data", out_data, 32'h5A41_4131);
        check("s1_count", 32'(conv_count), 32'd2);

        offer(2'b11, 32'h5B60_7A40, 4'hF, 1'b1, 1'b0);
        idle_begin();
        check("s2_data", out_data, 32'h5B60_5A40);
        check("s2_count", 32'(conv_count), 32'd3);

        offer(2'b10, 32'h4141_4141, 4'h5, 1'b0, 1'b0);
        idle_begin();
        check("s3_data", out_data, 32'h4161_4161);
        check("s3_keep", 32'(out_keep), 32'h5);
        check("s3_count", 32'(conv_count), 32'd5);

        // Back-pressure: third beat must stall until a pop frees a slot.
        drain();
        rdy_force = 1'b0;
        idle_begin();
        offer(2'b00, 32'h1111_1111, 4'hF, 1'b0, 1'b0);
        offer(2'b00, 32'h2222_2222, 4'hF, 1'b0, 1'b0);
        drive(2'b00, 32'h3333_3333, 4'hF, 1'b1, 1'b0, acc);
        check("full_stall", 32'(acc), 32'd0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(2'b00, 32'h3333_3333, 4'hF, 1'b1, 1'b0, acc);
        check("full_stall2", 32'(acc), 32'd0);
        rdy_force = 1'b1;
        offer(2'b00, 32'h3333_3333, 4'hF, 1'b1, 1'b0);
        check("third_after_pop", 32'(n_pop >= 1), 32'd1);
        drain();

        // Saturation and clear-wins on a 4-bit counter.
        drive(2'b00, 32'h0, 4'h0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) offer(2'b11, 32'h6161_6161, 4'hF, 1'b0, 1'b0);
        offer(2'b11, 32'h6161_6161, 4'h3, 1'b0, 1'b0);
        idle_begin();
        check("cnt_14", 32'(conv_count), 32'd14);
        offer(2'b11, 32'h6161_6161, 4'hF, 1'b0, 1'b0);
        idle_begin();
        check("cnt_sat", 32'(conv_count), 32'd15);
        offer(2'b11, 32'h6161_6161, 4'hF, 1'b0, 1'b1);
        idle_begin();
        check("cnt_clr_wins", 32'(conv_count), 32'd0);

        // Mid-stream asynchronous reset with two beats buffered.
        drain();
        rdy_force = 1'b0;
        offer(2'b01, 32'h6162_6364, 4'hF, 1'b0, 1'b0);
        offer(2'b01, 32'h6566_6768, 4'hF, 1'b1, 1'b0);
        idle_begin();
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_keep", 32'(out_keep), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_count", 32'(conv_count), 32'd0);
        sb.delete();
        n_acc   = 0;
        n_pop   = 0;
        exp_cnt = 0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        chk_en    = 1'b1;
        rdy_force = 1'b1;
        for (int i = 0; i < 3; i++) idle_begin();

        // Randomized traffic against the reference model.
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_begin();
            end else begin
                for (int b = 0; b < 4; b++) d[8*b +: 8] = rnd_byte();
                offer(2'($urandom_range(0, 3)), d, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            end
        end
        idle_begin();
        drain();
        check("accounting", 32'(n_acc), 32'(n_pop));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/case_stream_converter.md
CASE_STREAM_CONVERTER -- requirements
Module: case_stream_converter

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of byte lanes per beat (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the converted-character counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mode, input, 2 bits: conversion mode (00 pass, 01 upper, 10 lower, 11 toggle case).
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-008 The block SHALL have port in_data, input, 8*LANES bits: input bytes, lane 0 in bits [7:0].
REQ-009 The block SHALL have port in_keep, input, LANES bits: per-lane byte-valid mask.
REQ-010 The block SHALL have port in_last, input, 1 bit: marks the final beat of a frame.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the beat.
REQ-013 The block SHALL have port out_data, output, 8*LANES bits: converted bytes.
REQ-014 The block SHALL have port out_keep, output, LANES bits: the in_keep value carried with the beat.
REQ-015 The block SHALL have port out_last, output, 1 bit: the in_last value carried with the beat.
REQ-016 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of conv_count.
REQ-017 The block SHALL have port conv_count, output, CNT_W bits: saturating count of bytes changed.

Function
REQ-018 A beat SHALL be accepted in a cycle when in_valid=1 and in_ready=1, and SHALL be popped in a cycle when out_valid=1 and out_ready=1.
REQ-019 A byte SHALL be classed as a letter only if it is in 0x41-0x5A or 0x61-0x7A; every other byte value, including 0x80-0xFF, SHALL be passed through unchanged.
REQ-020 For a letter, only bit 5 SHALL change: mode 01 clears bit 5, mode 10 sets bit 5, mode 11 inverts bit 5, and mode 00 changes nothing.
REQ-021 A lane with keep=0 SHALL have its byte forwarded unchanged and SHALL NOT be counted.
REQ-022 mode SHALL be sampled per beat at acceptance, and a change of mode SHALL affect only beats accepted afterwards.
REQ-023 Conversion results SHALL be registered into a 2-entry FIFO; out_data, out_keep and out_last SHALL be driven from the FIFO head with no combinational path from the in_* ports.
REQ-024 Latency from acceptance to out_valid=1 SHALL be 1 cycle when the FIFO is empty.
REQ-025 Occupancy SHALL take the values 0, 1 or 2; in_ready SHALL equal (occupancy<2) and be a registered signal, independent of out_ready in the same cycle.
REQ-026 A simultaneous accept and pop SHALL leave occupancy unchanged and preserve beat order.
REQ-027 out_valid SHALL equal (occupancy>0).
REQ-028 Beats SHALL leave in acceptance order with no loss or duplication, and in_last SHALL stay aligned with its beat.
REQ-029 On each accept, conv_count SHALL increase by the number of lanes whose byte was actually modified (0..LANES).
REQ-030 conv_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-031 cnt_clr=1 SHALL set conv_count to 0 on the next edge, and SHALL win over a simultaneous increment.
REQ-032 The counter SHALL update in the acceptance cycle, independent of when the beat is popped.

Reset
REQ-033 While rst_n=0, asynchronously: occupancy=0, in_ready=0, out_valid=0, out_data=0, out_keep=0, out_last=0, conv_count=0.
REQ-034 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-stream SHALL discard all buffered beats; no partial beat SHALL appear after reset.

Verification
REQ-036 Scenario: LANES=4, mode=01, in_data=0x7A_41_61_31 ("1aAz", lane 0 first), keep=0xF -> next cycle out_data=0x5A_41_41_31; conv_count=2.
REQ-037 Scenario: mode=11, in_data=0x5B_60_7A_40, keep=0xF -> out_data=0x5B_60_5A_40; conv_count increases by 1 (boundary bytes 0x40, 0x5B and 0x60 are unchanged).
REQ-038 Scenario: mode=10, in_data=0x41_41_41_41, keep=0x5 -> out_data=0x41_61_41_61; conv_count increases by 2; out_keep=0x5.
REQ-039 Scenario: out_ready=0, three beats offered back-to-back -> first two accepted, in_ready=0 on the third; raise out_ready -> beats emerge in order, third accepted only after a pop.
REQ-040 Scenario: CNT_W=4, count at 14, accept a beat with 4 conversions -> conv_count=15; cnt_clr together with an accept -> conv_count=0.
REQ-041 Scenario: FIFO holding 2 beats, rst_n pulsed low between edges -> outputs zero immediately; after release, out_valid stays 0 until a new accept.
